// File: rtl/branch_redirect_if.sv
// ---------------------------------------------------------------------------
// branch_redirect_if : EX-stage branch inputs and front-end redirect outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface branch_redirect_if #(
  parameter int PC_W = 16
);
  logic            ex_valid;
  logic [4:0]      ex_opcode;
  logic            branch_sel;
  logic [PC_W-1:0] ex_target;
  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_if;
  logic            flush_id;

  modport master (
    output ex_valid, ex_opcode, branch_sel, ex_target, stall,
    input  redirect_valid, redirect_pc, flush_if, flush_id
  );

  modport slave (
    input  ex_valid, ex_opcode, branch_sel, ex_target, stall,
    output redirect_valid, redirect_pc, flush_if, flush_id
  );
endinterface

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl : one-shot PC redirect + IF/ID squash after EX branch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_redirect_ctrl #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  branch_redirect_if.slave      bus,
  input  wire logic             cnt_clr_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      branch_cnt_o,
  output logic [CNT_W-1:0]      taken_cnt_o
);

  localparam logic [4:0] c_op_b0 = 5'b10011;
  localparam logic [4:0] c_op_b1 = 5'b10100;
  localparam logic [4:0] c_op_b2 = 5'b10101;
  localparam logic [4:0] c_op_b3 = 5'b10110;
  localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       sq_cnt_q;
  logic             redirect_valid_q;
  logic             flush_q;
  logic             busy_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic is_branch;
  logic accept;

  assign is_branch = (bus.ex_opcode == c_op_b0) || (bus.ex_opcode == c_op_b1) ||
                     (bus.ex_opcode == c_op_b2) || (bus.ex_opcode == c_op_b3);
  // EX inputs only count while idle; anything arriving while busy is being squashed.
  assign accept    = (state_q == IDLE) && bus.ex_valid && !bus.stall && is_branch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      sq_cnt_q         <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      if (cnt_clr_i) begin
        branch_cnt_q <= '0;
        taken_cnt_q  <= '0;
      end else if (accept) begin
        branch_cnt_q <= sat_inc(branch_cnt_q);
        if (bus.branch_sel) taken_cnt_q <= sat_inc(taken_cnt_q);
      end

      case (state_q)
        IDLE: begin
          if (accept && bus.branch_sel) begin
            state_q          <= REDIRECT;
            redirect_pc_q    <= bus.ex_target;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            busy_q           <= 1'b1;
          end
        end
        REDIRECT: begin
          if (!bus.stall) begin
            redirect_valid_q <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_q <= IDLE;
              flush_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= SQUASH;
              sq_cnt_q <= c_flush_init;
            end
          end
        end
        SQUASH: begin
          if (!bus.stall) begin
            if (sq_cnt_q == 4'd1) begin
              state_q <= IDLE;
              flush_q <= 1'b0;
              busy_q  <= 1'b0;
            end
            sq_cnt_q <= sq_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if       = flush_q;
  assign bus.flush_id       = flush_q;
  assign busy_o             = busy_q;
  assign branch_cnt_o       = branch_cnt_q;
  assign taken_cnt_o        = taken_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl : vector table plus directed multi-cycle sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main build (FLUSH_CYCLES=2, CNT_W=16)
  branch_redirect_if #(.PC_W(16)) bif ();
  logic        clr_m;
  logic        busy_m;
  logic [15:0] bcnt_m, tcnt_m;
  branch_redirect_ctrl #(.PC_W(16), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .cnt_clr_i(clr_m),
    .busy_o(busy_m), .branch_cnt_o(bcnt_m), .taken_cnt_o(tcnt_m));

  // FLUSH_CYCLES=0 build
  branch_redirect_if #(.PC_W(16)) bif0 ();
  logic        clr_0;
  logic        busy_0;
  logic [15:0] bcnt_0, tcnt_0;
  branch_redirect_ctrl #(.PC_W(16), .FLUSH_CYCLES(0), .CNT_W(16)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .bus(bif0.slave), .cnt_clr_i(clr_0),
    .busy_o(busy_0), .branch_cnt_o(bcnt_0), .taken_cnt_o(tcnt_0));

  // CNT_W=4 build for saturation
  branch_redirect_if #(.PC_W(16)) bif4 ();
  logic       clr_4;
  logic       busy_4;
  logic [3:0] bcnt_4, tcnt_4;
  branch_redirect_ctrl #(.PC_W(16), .FLUSH_CYCLES(2), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4.slave), .cnt_clr_i(clr_4),
    .busy_o(busy_4), .branch_cnt_o(bcnt_4), .taken_cnt_o(tcnt_4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_m(input logic ev, input logic [4:0] op, input logic sel,
                         input logic [15:0] tgt, input logic st, input logic clr);
    bif.ex_valid = ev; bif.ex_opcode = op; bif.branch_sel = sel;
    bif.ex_target = tgt; bif.stall = st; clr_m = clr;
  endtask

  task automatic check_main(input string tag, input logic rv, input logic [15:0] pc,
                            input logic fl, input logic bz, input logic [15:0] bc,
                            input logic [15:0] tc);
    chk({tag, "_rv"},   32'(bif.redirect_valid), 32'(rv));
    chk({tag, "_pc"},   32'(bif.redirect_pc),    32'(pc));
    chk({tag, "_fif"},  32'(bif.flush_if),       32'(fl));
    chk({tag, "_fid"},  32'(bif.flush_id),       32'(fl));
    chk({tag, "_busy"}, 32'(busy_m),             32'(bz));
    chk({tag, "_bcnt"}, 32'(bcnt_m),             32'(bc));
    chk({tag, "_tcnt"}, 32'(tcnt_m),             32'(tc));
  endtask

  typedef struct {
    logic        ev;
    logic [4:0]  op;
    logic        sel;
    logic [15:0] tgt;
    logic        st;
    logic        clr;
    logic        e_rv;
    logic [15:0] e_pc;
    logic        e_fl;
    logic        e_busy;
    logic [15:0] e_b;
    logic [15:0] e_t;
  } vec_t;

  vec_t vt[17];
  int   pat[8];

  initial begin
    int busy_cycles;
    int rv_cycles;
    bit done;

    drive_m(0, 5'h00, 0, 16'h0, 0, 0);
    bif0.ex_valid = 0; bif0.ex_opcode = 0; bif0.branch_sel = 0; bif0.ex_target = 0; bif0.stall = 0;
    bif4.ex_valid = 0; bif4.ex_opcode = 0; bif4.branch_sel = 0; bif4.ex_target = 0; bif4.stall = 0;
    clr_0 = 0; clr_4 = 0;

    //              ev  op        sel tgt       st clr | rv pc       fl busy b   t
    vt[0]  = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[1]  = '{1'b1, 5'b10011, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'd1, 16'd1};
    vt[2]  = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b1, 16'd1, 16'd1};
    vt[3]  = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b1, 16'd1, 16'd1};
    vt[4]  = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'd1, 16'd1};
    vt[5]  = '{1'b1, 5'b10110, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[6]  = '{1'b1, 5'b00001, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[7]  = '{1'b0, 5'b10011, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[8]  = '{1'b1, 5'b10011, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[9]  = '{1'b1, 5'b10100, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 16'd3, 16'd2};
    vt[10] = '{1'b1, 5'b10101, 1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 16'd3, 16'd2};
    vt[11] = '{1'b1, 5'b10101, 1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 16'd3, 16'd2};
    vt[12] = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 16'd3, 16'd2};
    vt[13] = '{1'b1, 5'b10011, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'd0, 16'd0};
    vt[14] = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 16'd0, 16'd0};
    vt[15] = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 16'd0, 16'd0};
    vt[16] = '{1'b0, 5'h00,    1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'd0, 16'd0};

    pat = '{1, 1, 1, 0, 1, 1, 0, 0};

    // reset state, asserted from time zero
    repeat (2) @(negedge clk);
    check_main("rst", 0, 16'h0, 0, 0, 16'd0, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_m(vt[i].ev, vt[i].op, vt[i].sel, vt[i].tgt, vt[i].st, vt[i].clr);
      @(posedge clk); #1;
      check_main($sformatf("v%0d", i), vt[i].e_rv, vt[i].e_pc, vt[i].e_fl,
                 vt[i].e_busy, vt[i].e_b, vt[i].e_t);
    end

    // stalls: 3 cycles in REDIRECT, 2 in SQUASH
    @(negedge clk);
    drive_m(1, 5'b10011, 1, 16'h0200, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive_m(0, 5'h00, 0, 16'h0, 0, 0);
    busy_cycles = 0; rv_cycles = 0; done = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      if (!busy_m) done = 1;
      else begin
        busy_cycles++;
        if (bif.redirect_valid) rv_cycles++;
        chk($sformatf("stall_fl%0d", i), 32'(bif.flush_if & bif.flush_id), 32'd1);
        bif.stall = (i < 8) ? pat[i][0] : 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end
    bif.stall = 0;
    chk("stall_timeout", 32'(done), 32'd1);
    chk("stall_busy_cycles", 32'(busy_cycles), 32'd8);
    chk("stall_rv_cycles", 32'(rv_cycles), 32'd4);
    chk("stall_pc", 32'(bif.redirect_pc), 32'h0200);
    chk("stall_bcnt", 32'(bcnt_m), 32'd1);
    chk("stall_tcnt", 32'(tcnt_m), 32'd1);

    // FLUSH_CYCLES=0: busy exactly one cycle
    @(negedge clk);
    bif0.ex_valid = 1; bif0.ex_opcode = 5'b10110; bif0.branch_sel = 1; bif0.ex_target = 16'h0ABC;
    @(posedge clk);
    @(negedge clk);
    bif0.ex_valid = 0;
    busy_cycles = 0; rv_cycles = 0; done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (!busy_0) done = 1;
      else begin
        busy_cycles++;
        if (bif0.redirect_valid) rv_cycles++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("f0_timeout", 32'(done), 32'd1);
    chk("f0_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("f0_rv_cycles", 32'(rv_cycles), 32'd1);
    chk("f0_flush_after", 32'(bif0.flush_if | bif0.flush_id), 32'd0);
    chk("f0_pc", 32'(bif0.redirect_pc), 32'h0ABC);
    chk("f0_tcnt", 32'(tcnt_0), 32'd1);

    // CNT_W=4: 20 taken branches saturate at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bif4.ex_valid = 1; bif4.ex_opcode = 5'b10100; bif4.branch_sel = 1; bif4.ex_target = 16'(k);
      @(posedge clk);
      @(negedge clk);
      bif4.ex_valid = 0;
      done = 0;
      for (int j = 0; j < 8 && !done; j++) begin
        if (!busy_4) done = 1;
        else begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      if (!done) chk($sformatf("c4_timeout%0d", k), 32'(done), 32'd1);
    end
    chk("c4_bcnt_sat", 32'(bcnt_4), 32'd15);
    chk("c4_tcnt_sat", 32'(tcnt_4), 32'd15);
    chk("c4_pc", 32'(bif4.redirect_pc), 32'd19);
    @(negedge clk);
    bif4.ex_valid = 1; bif4.ex_opcode = 5'b10011; bif4.branch_sel = 1; bif4.ex_target = 16'h0BEE;
    clr_4 = 1;
    @(posedge clk); #1;
    chk("c4_clr_bcnt", 32'(bcnt_4), 32'd0);
    chk("c4_clr_tcnt", 32'(tcnt_4), 32'd0);
    chk("c4_clr_busy", 32'(busy_4), 32'd1);
    @(negedge clk);
    bif4.ex_valid = 0; clr_4 = 0;

    // async reset in the middle of SQUASH
    repeat (4) @(negedge clk);
    drive_m(1, 5'b10101, 1, 16'h0300, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive_m(0, 5'h00, 0, 16'h0, 0, 0);
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy_m), 32'd1);
    chk("pre_rst_rv", 32'(bif.redirect_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("arst", 0, 16'h0, 0, 0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_main($sformatf("post_rst%0d", i), 0, 16'h0, 0, 0, 16'd0, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
